// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA raster timing generator in the pixelClk domain.
//
// Two small FSMs (horizontal and vertical), each with a 10-bit phase counter
// that restarts on every state change, track the raster position. Every output
// is registered and decoded from the position the FSMs move to on the same
// edge, so each output reflects the position of the current cycle.
//
// Ports:
//   pixelClk   in   pixel clock
//   locked     in   asynchronous active-low reset (clock wizard lock)
//   hclk       out  horizontal sync, asserted level = SYNC_POL
//   vclk       out  vertical sync, asserted level = SYNC_POL
//   dValid_h   out  high while the horizontal position is in the active region
//   dValid_v   out  high while the line is in the vertical active region
//   xCor       out  active-region pixel column, 0 outside the active region
//   yCor       out  active-region line number, 0 outside the active region
//   frameStart out  one-cycle pulse on the first pixel of every frame
//   lineStart  out  one-cycle pulse on the first pixel of every line
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       pixelClk,
  input  logic       locked,
  output logic       hclk,
  output logic       vclk,
  output logic       dValid_h,
  output logic       dValid_v,
  output logic [9:0] xCor,
  output logic [9:0] yCor,
  output logic       frameStart,
  output logic       lineStart
);

  // Every segment is counted by its own 10-bit phase counter, so each length
  // must be 1..1024; the line/frame totals are never held in one counter.
  if (H_ACTIVE < 1 || H_ACTIVE > 1024 || H_FP < 1 || H_FP > 1024 ||
      H_SYNC   < 1 || H_SYNC   > 1024 || H_BP < 1 || H_BP > 1024 ||
      V_ACTIVE < 1 || V_ACTIVE > 1024 || V_FP < 1 || V_FP > 1024 ||
      V_SYNC   < 1 || V_SYNC   > 1024 || V_BP < 1 || V_BP > 1024) begin : g_bad_params
    $error("vga_sync_gen: every timing segment length must be in 1..1024");
  end

  localparam logic [9:0] H_ACT_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FRONT_LAST = 10'(H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BACK_LAST  = 10'(H_BP - 1);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FRONT_LAST = 10'(V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BACK_LAST  = 10'(V_BP - 1);
  localparam logic       SYNC_ON      = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    H_ACT   = 2'd0,
    H_FRONT = 2'd1,
    H_SYNCS = 2'd2,
    H_BACK  = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_ACT   = 2'd0,
    V_FRONT = 2'd1,
    V_SYNCS = 2'd2,
    V_BACK  = 2'd3
  } v_state_e;

  function automatic logic [9:0] h_last_idx(input h_state_e s);
    logic [9:0] r;
    case (s)
      H_ACT:   r = H_ACT_LAST;
      H_FRONT: r = H_FRONT_LAST;
      H_SYNCS: r = H_SYNC_LAST;
      H_BACK:  r = H_BACK_LAST;
      default: r = H_ACT_LAST;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] v_last_idx(input v_state_e s);
    logic [9:0] r;
    case (s)
      V_ACT:   r = V_ACT_LAST;
      V_FRONT: r = V_FRONT_LAST;
      V_SYNCS: r = V_SYNC_LAST;
      V_BACK:  r = V_BACK_LAST;
      default: r = V_ACT_LAST;
    endcase
    return r;
  endfunction

  function automatic h_state_e h_next(input h_state_e s);
    h_state_e r;
    case (s)
      H_ACT:   r = H_FRONT;
      H_FRONT: r = H_SYNCS;
      H_SYNCS: r = H_BACK;
      H_BACK:  r = H_ACT;
      default: r = H_ACT;
    endcase
    return r;
  endfunction

  function automatic v_state_e v_next(input v_state_e s);
    v_state_e r;
    case (s)
      V_ACT:   r = V_FRONT;
      V_FRONT: r = V_SYNCS;
      V_SYNCS: r = V_BACK;
      V_BACK:  r = V_ACT;
      default: r = V_ACT;
    endcase
    return r;
  endfunction

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  // run_q is low until the first edge after reset; that edge presents p=0,l=0
  // rather than advancing past it.
  logic       run_q;

  logic       hclk_q, vclk_q, dvh_q, dvv_q, fs_q, ls_q;
  logic [9:0] xcor_q, ycor_q;
  logic       hclk_d, vclk_d, dvh_d, dvv_d, fs_d, ls_d;
  logic [9:0] xcor_d, ycor_d;

  // Next raster position: horizontal phase advance, vertical step at end of line.
  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    if (!run_q) begin
      h_state_d = H_ACT;
      h_cnt_d   = 10'd0;
      v_state_d = V_ACT;
      v_cnt_d   = 10'd0;
    end else if (h_cnt_q == h_last_idx(h_state_q)) begin
      h_state_d = h_next(h_state_q);
      h_cnt_d   = 10'd0;
      // Leaving H_BACK is the end of a line; the vertical FSM steps on that edge.
      if (h_state_q == H_BACK) begin
        if (v_cnt_q == v_last_idx(v_state_q)) begin
          v_state_d = v_next(v_state_q);
          v_cnt_d   = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // Output decode from the next position so registered outputs carry no lag.
  always_comb begin
    dvh_d  = (h_state_d == H_ACT);
    dvv_d  = (v_state_d == V_ACT);
    xcor_d = 10'd0;
    ycor_d = 10'd0;
    if (dvh_d) begin
      xcor_d = h_cnt_d;
    end else begin
      xcor_d = 10'd0;
    end
    if (dvv_d) begin
      ycor_d = v_cnt_d;
    end else begin
      ycor_d = 10'd0;
    end
    if (h_state_d == H_SYNCS) begin
      hclk_d = SYNC_ON;
    end else begin
      hclk_d = ~SYNC_ON;
    end
    if (v_state_d == V_SYNCS) begin
      vclk_d = SYNC_ON;
    end else begin
      vclk_d = ~SYNC_ON;
    end
    ls_d = dvh_d && (h_cnt_d == 10'd0);
    fs_d = ls_d && dvv_d && (v_cnt_d == 10'd0);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      h_state_q <= H_ACT;
      v_state_q <= V_ACT;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      run_q     <= 1'b0;
      hclk_q    <= ~SYNC_ON;
      vclk_q    <= ~SYNC_ON;
      dvh_q     <= 1'b0;
      dvv_q     <= 1'b0;
      xcor_q    <= 10'd0;
      ycor_q    <= 10'd0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      run_q     <= 1'b1;
      hclk_q    <= hclk_d;
      vclk_q    <= vclk_d;
      dvh_q     <= dvh_d;
      dvv_q     <= dvv_d;
      xcor_q    <= xcor_d;
      ycor_q    <= ycor_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
    end
  end

  assign hclk       = hclk_q;
  assign vclk       = vclk_q;
  assign dValid_h   = dvh_q;
  assign dValid_v   = dvv_q;
  assign xCor       = xcor_q;
  assign yCor       = ycor_q;
  assign frameStart = fs_q;
  assign lineStart  = ls_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen. Three instances share clock and reset:
//   dut 0: small raster (25 px x 12 lines, 300 cycles/frame), SYNC_POL=0
//   dut 1: SVGA horizontal timing (1056 px/line), 5 lines, SYNC_POL=1
//   dut 2: default 640x480 timing (line-level behaviour only)
// Output vectors are packed as {hclk,vclk,dValid_h,dValid_v,xCor,yCor,frameStart,lineStart}.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic locked = 1'b0;
  always #5 clk = ~clk;

  logic       hs0, vs0, dh0, dv0, fs0, ls0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, dh1, dv1, fs1, ls1;
  logic [9:0] x1, y1;
  logic       hs2, vs2, dh2, dv2, fs2, ls2;
  logic [9:0] x2, y2;

  vga_sync_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)) u_small (
    .pixelClk(clk), .locked(locked), .hclk(hs0), .vclk(vs0), .dValid_h(dh0), .dValid_v(dv0),
    .xCor(x0), .yCor(y0), .frameStart(fs0), .lineStart(ls0));

  vga_sync_gen #(.H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
                 .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)) u_svga (
    .pixelClk(clk), .locked(locked), .hclk(hs1), .vclk(vs1), .dValid_h(dh1), .dValid_v(dv1),
    .xCor(x1), .yCor(y1), .frameStart(fs1), .lineStart(ls1));

  vga_sync_gen u_dflt (
    .pixelClk(clk), .locked(locked), .hclk(hs2), .vclk(vs2), .dValid_h(dh2), .dValid_v(dv2),
    .xCor(x2), .yCor(y2), .frameStart(fs2), .lineStart(ls2));

  logic [25:0] act0, act1, act2;
  assign act0 = {hs0, vs0, dh0, dv0, x0, y0, fs0, ls0};
  assign act1 = {hs1, vs1, dh1, dv1, x1, y1, fs1, ls1};
  assign act2 = {hs2, vs2, dh2, dv2, x2, y2, fs2, ls2};

  typedef struct {
    int          cyc;
    int          dut;
    logic [25:0] exp;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_cnt = 0;
  int   rel_cyc = 0;
  int   checks  = 0;
  int   errors  = 0;

  // Posedge counter; a sample at a negedge with count c belongs to position c-rel_cyc-1.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expected outputs at position k after release (k<0 means held in reset).
  function automatic logic [25:0] model(input int d, input int k);
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, p, l;
    logic pol, dvh, dvv, hcl, vcl, fs, ls;
    logic [9:0] xv, yv;
    case (d)
      0: begin ha = 16;  hf = 2;  hsw = 4;   hb = 3;  va = 6;   vf = 1;  vsw = 2; vb = 3;  pol = 1'b0; end
      1: begin ha = 800; hf = 40; hsw = 128; hb = 88; va = 2;   vf = 1;  vsw = 1; vb = 1;  pol = 1'b1; end
      default: begin ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; pol = 1'b0; end
    endcase
    if (k < 0) return {~pol, ~pol, 24'd0};
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    p   = k % ht;
    l   = (k / ht) % vt;
    dvh = (p < ha);
    dvv = (l < va);
    xv  = dvh ? p[9:0] : 10'd0;
    yv  = dvv ? l[9:0] : 10'd0;
    hcl = (p >= ha + hf && p < ha + hf + hsw) ? pol : ~pol;
    vcl = (l >= va + vf && l < va + vf + vsw) ? pol : ~pol;
    ls  = (p == 0);
    fs  = (p == 0) && (l == 0);
    return {hcl, vcl, dvh, dvv, xv, yv, fs, ls};
  endfunction

  task automatic push_sorted(input exp_t e);
    int i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > e.cyc) i--;
    sb_q.insert(i, e);
  endtask

  task automatic push_range(input int c_first, input int n, input bit in_rst, input string tag);
    exp_t e;
    for (int c = c_first; c < c_first + n; c++) begin
      for (int d = 0; d < 3; d++) begin
        e.cyc = c;
        e.dut = d;
        e.exp = model(d, in_rst ? -1 : (c - rel_cyc - 1));
        e.tag = tag;
        push_sorted(e);
      end
    end
  endtask

  task automatic push_dir(input int d, input int k, input logic [25:0] v, input string tag);
    exp_t e;
    e.cyc = rel_cyc + 1 + k;
    e.dut = d;
    e.exp = v;
    e.tag = tag;
    push_sorted(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: at every negedge pop and compare all entries due at this sample.
  initial begin
    exp_t e;
    logic [25:0] a;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
        e = sb_q.pop_front();
        checks++;
        case (e.dut)
          0: a = act0;
          1: a = act1;
          default: a = act2;
        endcase
        if (e.cyc < cyc_cnt) begin
          errors++;
          $display("FAIL %s stale: dut%0d cyc %0d sampled at %0d", e.tag, e.dut, e.cyc, cyc_cnt);
        end else if (a !== e.exp) begin
          errors++;
          $display("FAIL %s dut%0d cyc %0d: got %h required %h", e.tag, e.dut, e.cyc, a, e.exp);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int found;
    // Reset held for 10 cycles; outputs must sit at reset values.
    push_range(1, 9, 1'b1, "reset_hold");
    while (cyc_cnt < 10) @(negedge clk);
    #1;
    locked  = 1'b1;
    rel_cyc = cyc_cnt;

    // Hand-computed points: default timing line boundaries and sync window.
    push_dir(2, 0,   {1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1}, "dflt_first");
    push_dir(2, 639, {1'b1, 1'b1, 1'b1, 1'b1, 10'd639, 10'd0, 1'b0, 1'b0}, "dflt_last_act");
    push_dir(2, 655, {1'b1, 1'b1, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "dflt_pre_hsync");
    push_dir(2, 656, {1'b0, 1'b1, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "dflt_hsync_on");
    push_dir(2, 751, {1'b0, 1'b1, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "dflt_hsync_end");
    push_dir(2, 752, {1'b1, 1'b1, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "dflt_hsync_off");
    push_dir(2, 800, {1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 1'b0, 1'b1}, "dflt_line1");
    // Small raster: vsync line, frame wrap.
    push_dir(0, 175, {1'b1, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0, 1'b1}, "small_vsync");
    push_dir(0, 299, {1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0}, "small_wrap_pre");
    push_dir(0, 300, {1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1}, "small_wrap");
    // SVGA with active-high sync.
    push_dir(1, 839, {1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "svga_pre_hsync");
    push_dir(1, 840, {1'b1, 1'b0, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "svga_hsync_on");
    push_dir(1, 967, {1'b1, 1'b0, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "svga_hsync_end");
    push_dir(1, 968, {1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0}, "svga_hsync_off");
    push_dir(1, 1056, {1'b0, 1'b0, 1'b1, 1'b1, 10'd0,  10'd1, 1'b0, 1'b1}, "svga_line1");
    push_dir(1, 3168, {1'b0, 1'b1, 1'b1, 1'b0, 10'd0,  10'd0, 1'b0, 1'b1}, "svga_vsync");
    push_dir(1, 5280, {1'b0, 1'b0, 1'b1, 1'b1, 10'd0,  10'd0, 1'b1, 1'b1}, "svga_wrap");

    // Every cycle against the position model: two small frames, one SVGA frame.
    push_range(rel_cyc + 1, 5400, 1'b0, "run");
    drain(5450);

    // Mid-frame reset on the small raster at l=4, p=10.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (((cyc_cnt - rel_cyc - 1) % 300) == 110) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL midrst_seek: position l=4,p=10 not reached, required within 400 cycles");
    end
    // Reset drops between edges; the very next sample precedes any clock edge.
    locked = 1'b0;
    push_range(cyc_cnt, 3, 1'b1, "midrst_async");
    repeat (3) @(negedge clk);
    #1;
    locked  = 1'b1;
    rel_cyc = cyc_cnt;
    push_dir(0, 0,   {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}, "restart_first");
    push_dir(0, 300, {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}, "restart_next_frame");
    push_range(rel_cyc + 1, 700, 1'b0, "restart_run");
    drain(750);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
